ex_forward_ctrl: RTL and testbench
==================================

# ex_forward_ctrl

Pipeline-tracking forwarding and load-use hazard controller for the 64-bit core's execute stage. It shadows the destination-register bookkeeping of the ID/EX, EX/MEM and MEM/WB slots. Each cycle it produces the two 2-bit operand selects that drive the EX-stage 3-input 64-bit operand muxes (00 = register file, 01 = WB result, 10 = MEM ALU result). It also generates the load-use stall and inserts bubbles into its own ID/EX slot.

## Interface
- `REG_AW`, default 5: register address width.
- `CNT_W`, default 32: stall counter width.
- `clk` input 1: core clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `id_valid` input 1: the ID stage holds a real instruction.
- `id_rs1`, `id_rs2` input REG_AW: source registers of the instruction in ID.
- `id_rd` input REG_AW: destination register of the instruction in ID.
- `id_reg_write` input 1: the ID instruction writes `rd`.
- `id_mem_read` input 1: the ID instruction is a load.
- `flush` input 1: branch/jump redirect; kills the instruction entering EX.
- `forward_a` output 2: select for the EX operand A mux.
- `forward_b` output 2: select for the EX operand B mux.
- `stall` output 1: hold PC and IF/ID this cycle.
- `stall_count` output CNT_W: saturating count of stall cycles.

## Operation
- Three internal slots, ID/EX, EX/MEM and MEM/WB.
  - Each slot holds {valid, rd, reg_write, mem_read}.
  - ID/EX additionally holds rs1 and rs2.
- Bubble value for a slot: all fields 0.
- Each rising edge:
  - EX/MEM <= ID/EX.
  - MEM/WB <= EX/MEM.
  - ID/EX <= bubble if `flush` or `stall` is high; otherwise ID/EX <= ID inputs, with reg_write/mem_read forced to 0 when `id_valid`=0.
  - `flush` takes precedence over `stall`. Both only bubble ID/EX and never touch the older slots.
- `stall` is combinational and asserts when all of the following hold:
  - ID/EX.mem_read = 1,
  - ID/EX.rd != 0,
  - `id_valid` = 1,
  - ID/EX.rd == `id_rs1` or ID/EX.rd == `id_rs2`.
- `forward_a` is combinational, evaluated in priority order against ID/EX.rs1:
  - 2'b10 if EX/MEM.reg_write, EX/MEM.rd != 0 and EX/MEM.rd == ID/EX.rs1;
  - else 2'b01 if MEM/WB.reg_write, MEM/WB.rd != 0 and MEM/WB.rd == ID/EX.rs1;
  - else 2'b00.
- `forward_b` follows the same rules against ID/EX.rs2.
- 2'b11 is never driven.
- Register x0 is never forwarded and never causes a stall.
- `stall_count` increments by 1 on each edge where `stall`=1 and saturates at all-ones.

## Timing
- Reset values, asynchronous and immediate:
  - all slots are bubbles;
  - `forward_a` = `forward_b` = 2'b00;
  - `stall` = 0;
  - `stall_count` = 0.
- An instruction presented in ID in cycle n occupies ID/EX in cycle n+1. Its `forward_*` values are valid throughout cycle n+1, with zero added latency toward the muxes.
- Load-use penalty is exactly one stall cycle.
  - The load is in EX in cycle n+1, so `stall`=1 in that cycle.
  - In cycle n+2 the load is in MEM and the bubble is in EX; the consumer is still in ID, so `stall`=0.
  - The consumer enters EX in cycle n+3 with select 01 (from WB).
- When both EX/MEM and MEM/WB match the same source register, EX/MEM (younger) wins.
- If `flush` and `stall` are both high, ID/EX gets a bubble and `stall` remains asserted for that cycle. The upstream stage resolves the redirect.
- Reset asserted mid-operation clears all in-flight slots. No forwarding occurs from pre-reset instructions.

## Structure
- Shared core package:
  - `FWD_REG` = 2'b00, `FWD_WB` = 2'b01, `FWD_MEM` = 2'b10;
  - `REG_AW` default;
  - a packed slot struct {valid, rd, reg_write, mem_read}.
- One sub-module, `ctrl_slot_reg`: one slot register with async reset, a bubble input and a load enable. It is instanced three times.
- Comparators and priority logic stay in the top module.

## Test plan
- Back-to-back ALU ops: `addi x5` in ID, then `add x6,x5,x7` the next cycle → when `add` is in EX, `forward_a`=2'b10 and `forward_b`=2'b00; `stall` never rises.
- Two-apart dependency: `addi x5`, `nop`, then `sub x8,x1,x5` → when `sub` is in EX, `forward_b`=2'b01.
- Load-use: `ld x9` then `add x10,x9,x9` → `stall`=1 for exactly one cycle and `stall_count` goes 0→1. When `add` reaches EX, both selects are 2'b01.
- x0 and double match:
  - a writer to x0 followed by a reader of x0 → selects stay 2'b00 and `stall`=0;
  - `addi x3` twice in a row, then a reader of x3 → select is 2'b10 (EX/MEM wins).
- Flush: `flush`=1 while `addi x4` is in ID, then a reader of x4 follows → no forwarding ever matches x4, and selects stay 2'b00.
- Reset and saturation:
  - assert `reset` mid-stream → all outputs are 0 immediately;
  - with `CNT_W`=4, hold a load-use pattern for 20 stall cycles → `stall_count` stops at 15.

Source files
------------

// File: rtl/ex_forward_ctrl_pkg.sv
// Shared definitions for the EX-stage forwarding / load-use hazard controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package ex_forward_ctrl_pkg;

   // Default register-address width of the 64-bit core (32 architectural registers).
   localparam int unsigned REG_AW_DEFAULT = 5;

   // Operand-mux selects driven toward the EX-stage 3-input muxes.
   localparam logic [1:0] FWD_REG = 2'b00;  // register-file read data
   localparam logic [1:0] FWD_WB  = 2'b01;  // result being written back
   localparam logic [1:0] FWD_MEM = 2'b10;  // ALU result sitting in MEM

   // Destination bookkeeping carried by every pipeline slot at the default width.
   typedef struct packed {
      logic                      valid;
      logic [REG_AW_DEFAULT-1:0] rd;
      logic                      reg_write;
      logic                      mem_read;
   } slot_t;

   // Priority encode one operand's select: the younger producer (MEM) wins
   // over the older one (WB); 2'b11 is unreachable by construction.
   function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
      logic [1:0] sel;
      sel = FWD_REG;
      if (mem_hit) begin
         sel = FWD_MEM;
      end else if (wb_hit) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/ctrl_slot_reg.sv
// One pipeline control slot: a W-bit register that can be loaded or bubbled.
// Latency: one cycle from d_i to q_o; reset clears the slot immediately.
// Backpressure: none; bubble_i overrides load_i, load_i=0 holds the slot.
module ctrl_slot_reg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic         bubble_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] slot_q;
   logic [W-1:0] slot_d;

   // Next slot contents: a bubble (all zero) beats a load, otherwise hold.
   always_comb begin
      slot_d = slot_q;
      if (bubble_i) begin
         slot_d = '0;
      end else if (load_i) begin
         slot_d = d_i;
      end
   end

   // Slot storage; an asynchronous reset leaves a bubble behind.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign q_o = slot_q;

endmodule

// File: rtl/ex_forward_ctrl.sv
// Shadows ID/EX, EX/MEM, MEM/WB destination bookkeeping to drive EX operand selects and the load-use stall.
// Latency: selects valid the cycle an instruction sits in ID/EX, combinational from the slots; stall is combinational.
// Backpressure: stall holds PC and IF/ID for one cycle per load-use and bubbles ID/EX; flush bubbles ID/EX only.
module ex_forward_ctrl
   import ex_forward_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW = REG_AW_DEFAULT,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              flush,
   output logic [1:0]        forward_a,
   output logic [1:0]        forward_b,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_count
);

   // Slot layout at this instance's register width.
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              mem_read;
   } pipe_slot_t;

   // ID/EX additionally remembers the sources it will read in EX.
   typedef struct packed {
      pipe_slot_t        slot;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
   } idex_slot_t;

   localparam int unsigned SLOT_W = $bits(pipe_slot_t);
   localparam int unsigned IDEX_W = $bits(idex_slot_t);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   idex_slot_t       idex_d;
   idex_slot_t       idex_q;
   pipe_slot_t       exmem_q;
   pipe_slot_t       memwb_q;
   logic             idex_bubble;
   logic             mem_hit_a;
   logic             mem_hit_b;
   logic             wb_hit_a;
   logic             wb_hit_b;
   logic [CNT_W-1:0] stall_count_q;
   logic [CNT_W-1:0] stall_count_d;

   // Capture the ID instruction; an invalid ID slot must never look like a writer or a load.
   always_comb begin
      idex_d                = '0;
      idex_d.slot.valid     = id_valid;
      idex_d.slot.rd        = id_rd;
      idex_d.slot.reg_write = id_valid & id_reg_write;
      idex_d.slot.mem_read  = id_valid & id_mem_read;
      idex_d.rs1            = id_rs1;
      idex_d.rs2            = id_rs2;
   end

   // Redirect or load-use both replace the instruction entering EX with a bubble.
   assign idex_bubble = flush | stall;

   ctrl_slot_reg #(.W(IDEX_W)) u_idex (
      .clk      (clk),
      .reset    (reset),
      .load_i   (1'b1),
      .bubble_i (idex_bubble),
      .d_i      (idex_d),
      .q_o      (idex_q)
   );

   ctrl_slot_reg #(.W(SLOT_W)) u_exmem (
      .clk      (clk),
      .reset    (reset),
      .load_i   (1'b1),
      .bubble_i (1'b0),
      .d_i      (idex_q.slot),
      .q_o      (exmem_q)
   );

   ctrl_slot_reg #(.W(SLOT_W)) u_memwb (
      .clk      (clk),
      .reset    (reset),
      .load_i   (1'b1),
      .bubble_i (1'b0),
      .d_i      (exmem_q),
      .q_o      (memwb_q)
   );

   // The load/store flag of the oldest slot has no consumer here; it is kept so
   // all three slots carry identical bookkeeping.
   logic unused_memwb_mem_read;
   assign unused_memwb_mem_read = memwb_q.mem_read;

   // Producer-match detection; x0 is hard-wired zero so it is never forwarded.
   always_comb begin
      mem_hit_a = exmem_q.valid && exmem_q.reg_write && (exmem_q.rd != '0) && (exmem_q.rd == idex_q.rs1);
      mem_hit_b = exmem_q.valid && exmem_q.reg_write && (exmem_q.rd != '0) && (exmem_q.rd == idex_q.rs2);
      wb_hit_a  = memwb_q.valid && memwb_q.reg_write && (memwb_q.rd != '0) && (memwb_q.rd == idex_q.rs1);
      wb_hit_b  = memwb_q.valid && memwb_q.reg_write && (memwb_q.rd != '0) && (memwb_q.rd == idex_q.rs2);
   end

   // Operand selects with the younger producer taking priority.
   always_comb begin
      forward_a = fwd_sel(mem_hit_a, wb_hit_a);
      forward_b = fwd_sel(mem_hit_b, wb_hit_b);
   end

   // Load in EX whose result a real ID instruction needs next cycle: hold one cycle.
   always_comb begin
      stall = idex_q.slot.mem_read && (idex_q.slot.rd != '0) && id_valid &&
              ((idex_q.slot.rd == id_rs1) || (idex_q.slot.rd == id_rs2));
   end

   // Stall-cycle counter, saturating at all-ones.
   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + CNT_ONE;
      end
   end

   // Counter storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Self-checking bench for ex_forward_ctrl: vector table plus reset and saturation sequences.
// Latency: expectations are per cycle, sampled 1 time unit after the driving negedge.
// Backpressure: stalls are honoured by the vectors repeating the held ID instruction.
module tb_ex_forward_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_reg_write, id_mem_read, flush;
   logic [1:0]  forward_a, forward_b;
   logic        stall;
   logic [31:0] stall_count;
   logic [1:0]  fa4, fb4;
   logic        st4;
   logic [3:0]  cnt4;

   always #5 clk = ~clk;

   ex_forward_ctrl dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
      .forward_a(forward_a), .forward_b(forward_b), .stall(stall), .stall_count(stall_count)
   );

   ex_forward_ctrl #(.REG_AW(5), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
      .forward_a(fa4), .forward_b(fb4), .stall(st4), .stall_count(cnt4)
   );

   typedef struct {
      logic       valid;
      logic [4:0] rs1, rs2, rd;
      logic       rw, mr, fl;
      logic [1:0] ea, eb;
      logic       es;
      int         ec;
   } vec_t;

   typedef struct {
      logic [1:0] fa, fb;
      logic       st;
      int         cnt;
      int         cnt4;
      int         tag;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t mk(input logic v, input int rs1, input int rs2, input int rd,
                               input logic rw, input logic mr, input logic fl,
                               input int ea, input int eb, input logic es, input int ec);
      vec_t r;
      r.valid = v;   r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
      r.rw = rw;     r.mr = mr;       r.fl = fl;
      r.ea = 2'(ea); r.eb = 2'(eb);   r.es = es;      r.ec = ec;
      return r;
   endfunction

   function automatic vec_t nop(input int ea, input int eb, input logic es, input int ec);
      return mk(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, ea, eb, es, ec);
   endfunction

   task automatic check(input string nm, input int tag, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (row %0d): got %0d, expected %0d", nm, tag, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      id_valid = v.valid; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
      id_reg_write = v.rw; id_mem_read = v.mr; flush = v.fl;
   endtask

   task automatic compare_front();
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard: got empty queue, expected an entry");
      end else begin
         e = sb.pop_front();
         check("forward_a",   e.tag, longint'(forward_a),   longint'(e.fa));
         check("forward_b",   e.tag, longint'(forward_b),   longint'(e.fb));
         check("stall",       e.tag, longint'(stall),       longint'(e.st));
         check("stall_count", e.tag, longint'(stall_count), longint'(e.cnt));
         check("cnt4",        e.tag, longint'(cnt4),        longint'(e.cnt4));
         check("forward_a4",  e.tag, longint'(fa4),         longint'(e.fa));
         check("forward_b4",  e.tag, longint'(fb4),         longint'(e.fb));
         check("stall4",      e.tag, longint'(st4),         longint'(e.st));
      end
   endtask

   // One cycle: drive at negedge, queue the expectation, compare 1 unit later.
   task automatic step(input vec_t v, input int tag);
      exp_t e;
      @(negedge clk);
      drive(v);
      e.fa = v.ea; e.fb = v.eb; e.st = v.es; e.cnt = v.ec;
      e.cnt4 = (v.ec > 15) ? 15 : v.ec;
      e.tag = tag;
      sb.push_back(e);
      #1;
      compare_front();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e0;
      reset = 1'b1;
      drive(nop(0, 0, 1'b0, 0));

      // row: valid rs1 rs2 rd rw mr fl | fwd_a fwd_b stall count (this cycle)
      tbl.push_back(nop(0, 0, 1'b0, 0));                       // 0
      tbl.push_back(mk(1, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0));      // 1  addi x5
      tbl.push_back(mk(1, 5, 7, 6, 1, 0, 0, 0, 0, 0, 0));      // 2  add x6,x5,x7
      tbl.push_back(nop(2, 0, 1'b0, 0));                       // 3  add in EX: MEM on A
      tbl.push_back(mk(1, 2, 0, 5, 1, 0, 0, 0, 0, 0, 0));      // 4  addi x5
      tbl.push_back(nop(0, 0, 1'b0, 0));                       // 5
      tbl.push_back(mk(1, 1, 5, 8, 1, 0, 0, 0, 0, 0, 0));      // 6  sub x8,x1,x5
      tbl.push_back(nop(0, 1, 1'b0, 0));                       // 7  sub in EX: WB on B
      tbl.push_back(nop(0, 0, 1'b0, 0));                       // 8
      tbl.push_back(mk(1, 2, 0, 9, 1, 1, 0, 0, 0, 0, 0));      // 9  ld x9
      tbl.push_back(mk(1, 9, 9, 10, 1, 0, 0, 0, 0, 1, 0));     // 10 add x10,x9,x9 -> stall
      tbl.push_back(mk(1, 9, 9, 10, 1, 0, 0, 0, 0, 0, 1));     // 11 held, no stall
      tbl.push_back(nop(1, 1, 1'b0, 1));                       // 12 add in EX: WB both
      tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1));      // 13 addi x0
      tbl.push_back(mk(1, 0, 0, 11, 1, 0, 0, 0, 0, 0, 1));     // 14 reader of x0
      tbl.push_back(nop(0, 0, 1'b0, 1));                       // 15 no x0 forwarding
      tbl.push_back(mk(1, 3, 0, 0, 1, 1, 0, 0, 0, 0, 1));      // 16 ld x0
      tbl.push_back(mk(1, 0, 0, 12, 1, 0, 0, 0, 0, 0, 1));     // 17 reader of x0: no stall
      tbl.push_back(nop(0, 0, 1'b0, 1));                       // 18
      tbl.push_back(mk(1, 1, 0, 3, 1, 0, 0, 0, 0, 0, 1));      // 19 addi x3
      tbl.push_back(mk(1, 1, 0, 3, 1, 0, 0, 0, 0, 0, 1));      // 20 addi x3
      tbl.push_back(mk(1, 3, 3, 13, 1, 0, 0, 0, 0, 0, 1));     // 21 add x13,x3,x3
      tbl.push_back(nop(2, 2, 1'b0, 1));                       // 22 EX/MEM wins
      tbl.push_back(mk(1, 1, 0, 4, 1, 0, 1, 0, 0, 0, 1));      // 23 addi x4 flushed
      tbl.push_back(mk(1, 4, 4, 14, 1, 0, 0, 0, 0, 0, 1));     // 24 reader of x4
      tbl.push_back(nop(0, 0, 1'b0, 1));                       // 25 no forwarding of x4
      tbl.push_back(nop(0, 0, 1'b0, 1));                       // 26
      tbl.push_back(mk(1, 2, 0, 9, 1, 1, 0, 0, 0, 0, 1));      // 27 ld x9
      tbl.push_back(mk(1, 9, 9, 10, 1, 0, 1, 0, 0, 1, 1));     // 28 flush+stall: stall stays
      tbl.push_back(nop(0, 0, 1'b0, 2));                       // 29
      tbl.push_back(nop(0, 0, 1'b0, 2));                       // 30
      tbl.push_back(mk(0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 2));      // 31 invalid "ld x5"
      tbl.push_back(mk(1, 5, 5, 15, 1, 0, 0, 0, 0, 0, 2));     // 32 no stall behind it
      tbl.push_back(nop(0, 0, 1'b0, 2));                       // 33 no forwarding from it
      tbl.push_back(nop(0, 0, 1'b0, 2));                       // 34
      tbl.push_back(mk(1, 1, 0, 7, 1, 1, 0, 0, 0, 0, 2));      // 35 ld x7
      tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 2));      // 36 invalid ID: no stall
      tbl.push_back(nop(2, 0, 1'b0, 2));                       // 37
      tbl.push_back(nop(0, 0, 1'b0, 2));                       // 38

      // Reset state while reset is held.
      #2;
      e0.fa = 2'b00; e0.fb = 2'b00; e0.st = 1'b0; e0.cnt = 0; e0.cnt4 = 0; e0.tag = -1;
      sb.push_back(e0);
      compare_front();
      @(negedge clk);
      reset = 1'b0;

      foreach (tbl[i]) step(tbl[i], i);

      // Mid-stream reset: live forwarding and a live stall vanish at once.
      step(mk(1, 1, 0, 5, 1, 0, 0, 0, 0, 0, 2), 100);
      step(mk(1, 5, 5, 6, 1, 0, 0, 0, 0, 0, 2), 101);
      step(mk(1, 0, 0, 9, 1, 1, 0, 2, 2, 0, 2), 102);
      step(mk(1, 9, 9, 10, 1, 0, 0, 0, 0, 1, 2), 103);
      #1 reset = 1'b1;
      #1;
      e0.tag = 104;
      sb.push_back(e0);
      compare_front();
      @(negedge clk);
      drive(nop(0, 0, 1'b0, 0));
      reset = 1'b0;
      step(nop(0, 0, 1'b0, 0), 105);
      step(mk(1, 5, 6, 7, 1, 0, 0, 0, 0, 0, 0), 106);          // reads pre-reset x5/x6
      step(nop(0, 0, 1'b0, 0), 107);                           // nothing forwarded

      // Saturation: a load into x9 that itself reads x9 stalls every other cycle.
      @(negedge clk);
      drive(nop(0, 0, 1'b0, 0));
      reset = 1'b1;
      #2 reset = 1'b0;
      for (int i = 0; i < 42; i++) begin
         step(mk(1, 9, 0, 9, 0, 1, 0, 0, 0, (i % 2) == 1, i / 2), 200 + i);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
